regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file for the ARM datapath, replacing the fixed two-read, negedge-write file. It provides NUM_RD combinational read ports, a rising-edge write port, PC substitution on the top index, and a hardware clear sequencer that zeroes all storage after reset or on request. Decode uses it as the architectural GPR file; the third read port serves register-shifted-register operands.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 4, index width; storage holds 2**ADDR_W-1 entries, and index 2**ADDR_W-1 is the PC
- NUM_RD, 3, number of read ports (1..4)

- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  synchronous, active-low reset
- we  in  1  write enable
- wa  in  ADDR_W  write index
- wd  in  DATA_W  write data
- r15  in  DATA_W  PC+8 value returned on reads of the PC index
- ra  in  NUM_RD×ADDR_W  packed read indices; port i is bits [i*ADDR_W +: ADDR_W]
- rd  out  NUM_RD×DATA_W  packed read data, same packing as ra
- clr_req  in  1  request a full clear sweep
- busy  out  1  clear sweep in progress
- wr_drop  out  1  a write was discarded this cycle

## Operation
- States: SWEEP and IDLE. Reset (reset_n low at an edge) forces SWEEP with ptr=0 and takes priority over everything else.
- SWEEP: at each edge, rf[ptr] <= 0 and ptr <= ptr+1. At the edge where ptr = 2**ADDR_W-2, the next state is IDLE.
- IDLE, write: if we=1, wa writes rf[wa] <= wd at the edge.
- IDLE, clear: clr_req=1 moves the state to SWEEP with ptr=0 at the next edge. If we and clr_req are both high, the write still occurs, and the sweep later zeroes it.
- clr_req in SWEEP is ignored; the sweep does not restart.
- Writes while busy are discarded. wr_drop = we & busy, combinationally.
- A write to the PC index is always discarded silently: no storage and no wr_drop.
- Read port i, selected in priority order:
  - ra=PC: returns r15
  - else busy=1: returns 0
  - else bypass hit (macro-dependent, see Configuration): returns wd
  - else: returns rf[ra]
- ptr width is ADDR_W. It never wraps, because the sweep stops at the last storage index.

## Timing
- Reset values:
  - busy=1 from the first reset edge
  - wr_drop = we
  - rd = r15 for PC indices, 0 otherwise
  - All storage reaches 0 by the end of the sweep.
- Sweep length is 2**ADDR_W-1 edges (15 by default). busy falls in the cycle after the 15th edge following reset release or clr_req acceptance.
- Reads are combinational, with zero-cycle latency from ra to rd.
- Write latency: one edge. Without bypass, a read of wa returns the new value in the cycle after the write edge.
- Reset mid-sweep restarts at ptr=0. A full sweep is always required after the final reset edge.

## Configuration
- REGFILE_BYPASS_EN defined: when we=1, busy=0, wa≠PC and ra[i]=wa, rd[i]=wd in the same cycle. This write-first forwarding restores the same-cycle visibility of the old negedge-write file.
- REGFILE_BYPASS_EN undefined: no forwarding; rd[i] returns the pre-write value in the write cycle.

## Structure
- Package regfile_pkg holds:
  - the state enum, sweep_state_t {SWEEP, IDLE}
  - the default DATA_W/ADDR_W constants
  - the function pc_idx(ADDR_W) = 2**ADDR_W-1
- Sub-module regfile_clear_seq: the state register, ptr counter, busy, clear-write strobe and index. The top instantiates it and muxes the host write against the clear write.

## Test plan
- Reset for 2 cycles, release:
  - busy=1 for exactly 15 cycles, then 0
  - all ra 0..14 read 0
  - ra=15 with r15=0x0000_0108 reads 0x0000_0108
- Idle write, no macro: we=1, wa=3, wd=0xDEAD_BEEF.
  - rd[0] at ra=3 reads old 0 in the write cycle
  - reads 0xDEAD_BEEF next cycle
  - the same values appear on all NUM_RD ports simultaneously
- With REGFILE_BYPASS_EN, the same stimulus returns 0xDEAD_BEEF in the write cycle. A write to wa=15 is discarded, and rd for ra=15 stays r15.
- Fill entries 0..14 with 0x100+i, pulse clr_req:
  - busy rises next cycle
  - a we=1 to wa=2 during the sweep asserts wr_drop and does not update
  - after 15 edges all entries read 0
  - clr_req held high during the sweep does not extend it
- Reset asserted at sweep edge 7: the sweep restarts, and busy stays high for 15 cycles after release.
- we and clr_req in the same IDLE cycle:
  - the write lands (visible through a read only after busy, so entry reads 0 post-sweep)
  - wr_drop=0 in that cycle

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file and its clear sequencer.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic {
        SWEEP,
        IDLE
    } sweep_state_t;

    // The top index is reserved for the PC and has no storage behind it.
    function automatic int pc_idx(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks ptr over every storage entry after reset or on clr_req.
//
// state | meaning
// SWEEP | zeroing rf[ptr] at each edge; busy high, host writes dropped
// IDLE  | normal operation; clr_req starts a new sweep from entry 0
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(pc_idx(ADDR_W) - 1);

    sweep_state_t      state;
    logic [ADDR_W-1:0] ptr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= SWEEP;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                SWEEP: begin
                    // ptr stops one past LAST; it is reloaded before the next sweep
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state <= SWEEP;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign clr_we  = busy;
    assign clr_idx = ptr;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port GPR file with PC substitution on the top index and a hardware clear sweep.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [DATA_W-1:0]        r15,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int                NUM_ENT = pc_idx(ADDR_W);
    localparam logic [ADDR_W-1:0] PC      = ADDR_W'(pc_idx(ADDR_W));

    logic [DATA_W-1:0] rf [NUM_ENT];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              wa_is_pc;
    logic              host_we;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    // PC writes vanish without flagging a drop; only real entries can be dropped.
    assign wa_is_pc = (wa == PC);
    assign host_we  = we & ~busy & ~wa_is_pc;
    assign wr_drop  = we & busy & ~wa_is_pc;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            rf[clr_idx] <= '0;
        end else if (host_we) begin
            rf[wa] <= wd;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;

        assign idx = ra[g*ADDR_W +: ADDR_W];

        always_comb begin
            data = '0;
            if (idx == PC) begin
                data = r15;
            end else if (busy) begin
                data = '0;
`ifdef REGFILE_BYPASS_EN
            end else if (we && (idx == wa)) begin
                data = wd;
`endif
            end else begin
                data = rf[idx];
            end
        end

        assign rd[g*DATA_W +: DATA_W] = data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expected values queued when stimulus is driven, popped at each check.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NUM_RD = 3;

    logic                     clk;
    logic                     reset_n;
    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic [DATA_W-1:0]        r15;
    logic [NUM_RD*ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic                     clr_req;
    logic                     busy;
    logic                     wr_drop;

    logic [31:0] exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cnt;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_mp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .r15     (r15),
        .ra      (ra),
        .rd      (rd),
        .clr_req (clr_req),
        .busy    (busy),
        .wr_drop (wr_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rdp(input int i);
        return rd[i*DATA_W +: DATA_W];
    endfunction

    task automatic set_ra(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        ra = {a2, a1, a0};
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    // Counts samples with busy high, starting at the current sample; drops clr_req/we at drop_at.
    task automatic count_busy(input int drop_at, output int n);
        int guard;
        n = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 64) begin
            n++;
            if (n == drop_at) begin
                clr_req = 1'b0;
                we      = 1'b0;
            end
            @(negedge clk);
            #1;
            guard++;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        we      = 1'b0;
        wa      = '0;
        wd      = '0;
        r15     = 32'h0000_0108;
        clr_req = 1'b0;
        set_ra(4'd15, 4'd0, 4'd7);

        // reset held for two edges
        @(negedge clk); #1;
        push(32'h1);          check("rst_busy", 32'(busy));
        push(32'h0000_0108);  check("rst_rd_pc", rdp(0));
        push(32'h0);          check("rst_rd1", rdp(1));
        push(32'h0);          check("rst_rd2", rdp(2));
        we = 1'b1; wa = 4'd2; #1;
        push(32'h1);          check("rst_wr_drop", 32'(wr_drop));
        we = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; #1;
        count_busy(0, cnt);
        push(32'd15);         check("post_reset_busy_len", 32'(cnt));

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            set_ra(4'(i), 4'(14 - i), 4'd15); #1;
            push(32'h0);          check("init_rd0", rdp(0));
            push(32'h0);          check("init_rd1", rdp(1));
            push(32'h0000_0108);  check("init_rd_pc", rdp(2));
        end

        // idle write to entry 3
        @(negedge clk);
        we = 1'b1; wa = 4'd3; wd = 32'hDEAD_BEEF; set_ra(4'd3, 4'd3, 4'd3); #1;
        for (int p = 0; p < NUM_RD; p++) begin
            push(BYP ? 32'hDEAD_BEEF : 32'h0); check("wr_cycle_rd", rdp(p));
        end
        push(32'h0);  check("idle_wr_drop", 32'(wr_drop));
        @(negedge clk);
        we = 1'b0; #1;
        for (int p = 0; p < NUM_RD; p++) begin
            push(32'hDEAD_BEEF); check("after_wr_rd", rdp(p));
        end

        // PC write is silently discarded
        @(negedge clk);
        r15 = 32'h0000_0ABC;
        we = 1'b1; wa = 4'd15; wd = 32'h1234_5678; set_ra(4'd15, 4'd15, 4'd3); #1;
        push(32'h0000_0ABC);  check("pc_wr_rd_pc", rdp(0));
        push(32'hDEAD_BEEF);  check("pc_wr_rd3", rdp(2));
        push(32'h0);          check("pc_wr_drop", 32'(wr_drop));
        @(negedge clk);
        we = 1'b0; #1;
        push(32'h0000_0ABC);  check("pc_after_rd", rdp(1));
        push(32'hDEAD_BEEF);  check("pc_after_rd3", rdp(2));

        // fill all entries
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            we = 1'b1; wa = 4'(i); wd = 32'h100 + 32'(i);
        end
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            set_ra(4'(i), 4'(i), 4'd15); #1;
            push(32'h100 + 32'(i)); check("fill_rd", rdp(1));
        end

        // clear sweep with clr_req held and a dropped write
        @(negedge clk);
        clr_req = 1'b1; set_ra(4'd2, 4'd15, 4'd0); #1;
        push(32'h0);          check("clr_accept_busy", 32'(busy));
        push(32'h102);        check("clr_accept_rd", rdp(0));
        @(negedge clk);
        we = 1'b1; wa = 4'd2; wd = 32'h0000_FFFF; #1;
        push(32'h1);          check("sweep_busy", 32'(busy));
        push(32'h1);          check("sweep_wr_drop", 32'(wr_drop));
        push(32'h0);          check("sweep_rd_zero", rdp(0));
        push(32'h0000_0ABC);  check("sweep_rd_pc", rdp(1));
        count_busy(8, cnt);
        push(32'd15);         check("clr_busy_len", 32'(cnt));
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            set_ra(4'(i), 4'd15, 4'd15); #1;
            push(32'h0); check("post_clr_rd", rdp(0));
        end

        // reset at sweep edge 7
        @(negedge clk);
        we = 1'b1; wa = 4'd5; wd = 32'h55;
        @(negedge clk);
        we = 1'b0; set_ra(4'd5, 4'd15, 4'd15); #1;
        push(32'h55);         check("pre_midrst_rd", rdp(0));
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk); #1;
        push(32'h1);          check("midrst_busy", 32'(busy));
        reset_n = 1'b1;
        count_busy(0, cnt);
        push(32'd15);         check("midrst_busy_len", 32'(cnt));
        @(negedge clk); #1;
        push(32'h0);          check("midrst_rd5", rdp(0));

        // write and clr_req in the same idle cycle
        @(negedge clk);
        we = 1'b1; wa = 4'd4; wd = 32'h44; clr_req = 1'b1; set_ra(4'd4, 4'd15, 4'd15); #1;
        push(32'h0);          check("wc_wr_drop", 32'(wr_drop));
        push(32'h0);          check("wc_busy", 32'(busy));
        push(BYP ? 32'h44 : 32'h0); check("wc_rd", rdp(0));
        @(negedge clk);
        we = 1'b0; clr_req = 1'b0; #1;
        count_busy(0, cnt);
        push(32'd15);         check("wc_busy_len", 32'(cnt));
        @(negedge clk); #1;
        push(32'h0);          check("wc_rd_after", rdp(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
